// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM with byte-strobed writes, optional write-to-read
// bypass and a clear sequencer that fills the array with INIT_VALUE.
`timescale 1ns/1ps

module lut_ram_mp #(
    parameter int                   LUT_WIDTH    = 32,
    parameter int                   LUT_DEPTH    = 256,
    parameter int                   NUM_RD_PORTS = 2,
    parameter bit                   BYTE_WR_EN   = 1'b1,
    parameter bit                   WR_BYPASS    = 1'b1,
    parameter logic [LUT_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int                  AW           = $clog2(LUT_DEPTH),
    localparam int                  NB           = (LUT_WIDTH >= 8) ? LUT_WIDTH / 8 : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [LUT_WIDTH-1:0]              wr_data,
    input  logic [NB-1:0]                     wr_strb,
    input  logic [NUM_RD_PORTS*AW-1:0]        rd_addr,
    output logic [NUM_RD_PORTS*LUT_WIDTH-1:0] rd_data,
    input  logic                              clear_req,
    output logic                              busy
);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(LUT_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(LUT_DEPTH - 1);

    state_e                 state_q;
    logic [AW-1:0]          clr_addr_q;
    logic                   busy_q;
    logic [LUT_WIDTH-1:0]   mem_q [LUT_DEPTH];

    logic                   wr_in_range;
    logic                   user_we;
    logic [LUT_WIDTH-1:0]   wr_mask;
    logic [LUT_WIDTH-1:0]   wr_old;
    logic [LUT_WIDTH-1:0]   wr_merged;

    // Bit-level write mask; with strobes disabled every write is a full word.
    if (BYTE_WR_EN) begin : g_strb
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        end
    end else begin : g_full
        assign wr_mask = '1;
    end

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign user_we     = rst_n && (state_q == S_IDLE) && wr_en && wr_in_range;
    assign wr_old      = mem_q[wr_addr];
    assign wr_merged   = (wr_old & ~wr_mask) | (wr_data & wr_mask);

    // Sequencer: busy is registered alongside the state so it never glitches.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else if (state_q == S_CLEAR) begin
            if (clr_addr_q == LAST_ADDR) begin
                state_q    <= S_IDLE;
                clr_addr_q <= '0;
                busy_q     <= 1'b0;
            end else begin
                clr_addr_q <= clr_addr_q + AW'(1);
            end
        end else if (clear_req) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end
    end

    // NOTE: the array has no reset; the clear sweep initialises it, which keeps it mappable to LUT RAM.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_addr_q] <= INIT_VALUE;
        end else if (user_we) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]        ra;
        logic                 ra_in_range;
        logic [LUT_WIDTH-1:0] rword;

        assign ra          = rd_addr[p*AW +: AW];
        assign ra_in_range = {1'b0, ra} < DEPTH_EXT;

        // NOTE: rword gets a default first so no path through the block infers a latch.
        always_comb begin
            rword = INIT_VALUE;
            if (!busy_q && ra_in_range) begin
                if (WR_BYPASS && user_we && (ra == wr_addr)) begin
                    rword = wr_merged;
                end else begin
                    rword = mem_q[ra];
                end
            end
        end

        assign rd_data[p*LUT_WIDTH +: LUT_WIDTH] = rword;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_lut_ram_mp.sv
// Directed bench for lut_ram_mp: three instances (bypass, no-bypass, odd depth)
// checked through an expected-value queue.
`timescale 1ns/1ps

module tb_lut_ram_mp;

    localparam logic [31:0] A_INIT = 32'hDEAD_BEEF;
    localparam logic [31:0] C_INIT = 32'hC0DE_0012;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en_a, wr_en_b, wr_en_c;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        clear_req_a, no_clr;
    logic [7:0]  rd_addr_a, rd_addr_b;
    logic [11:0] rd_addr_c;
    logic [63:0] rd_data_a, rd_data_b;
    logic [95:0] rd_data_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    lut_ram_mp #(.LUT_WIDTH(32), .LUT_DEPTH(16), .NUM_RD_PORTS(2), .BYTE_WR_EN(1'b1),
                 .WR_BYPASS(1'b1), .INIT_VALUE(A_INIT)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .clear_req(clear_req_a), .busy(busy_a));

    lut_ram_mp #(.LUT_WIDTH(32), .LUT_DEPTH(16), .NUM_RD_PORTS(2), .BYTE_WR_EN(1'b1),
                 .WR_BYPASS(1'b0), .INIT_VALUE(32'h0)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .clear_req(no_clr), .busy(busy_b));

    lut_ram_mp #(.LUT_WIDTH(32), .LUT_DEPTH(12), .NUM_RD_PORTS(3), .BYTE_WR_EN(1'b1),
                 .WR_BYPASS(1'b1), .INIT_VALUE(C_INIT)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .clear_req(no_clr), .busy(busy_c));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $error("FAIL sb_empty: observed %h, required a queued expectation", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s: observed %h, required %h", e.tag, obs, e.exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until each busy drops; 0 expected means that instance is not checked.
    task automatic wait_clear(input string tag, input int ea, input int eb, input int ec);
        int na = 0, nb = 0, nc = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (na == 0 && !busy_a) na = i;
            if (nb == 0 && !busy_b) nb = i;
            if (nc == 0 && !busy_c) nc = i;
            if (na != 0 && nb != 0 && nc != 0) break;
        end
        push({tag, "_cyc_a"}, 32'(ea)); pop_chk(32'(na));
        if (eb > 0) begin push({tag, "_cyc_b"}, 32'(eb)); pop_chk(32'(nb)); end
        if (ec > 0) begin push({tag, "_cyc_c"}, 32'(ec)); pop_chk(32'(nc)); end
    endtask

    task automatic read_all_a(input string tag, input logic [31:0] v);
        for (int i = 0; i < 16; i++) begin
            cyc();
            rd_addr_a = {4'(15 - i), 4'(i)};
            push($sformatf("%s_a0_%0d", tag, i), v);
            push($sformatf("%s_a1_%0d", tag, 15 - i), v);
            #1;
            pop_chk(rd_data_a[31:0]);
            pop_chk(rd_data_a[63:32]);
        end
    endtask

    task automatic read_all_c(input string tag, input logic [31:0] v);
        for (int i = 0; i < 12; i++) begin
            cyc();
            rd_addr_c = {4'((i + 5) % 12), 4'(11 - i), 4'(i)};
            for (int p = 0; p < 3; p++) push($sformatf("%s_c%0d_%0d", tag, p, i), v);
            #1;
            pop_chk(rd_data_c[31:0]);
            pop_chk(rd_data_c[63:32]);
            pop_chk(rd_data_c[95:64]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {wr_en_a, wr_en_b, wr_en_c, clear_req_a, no_clr} = '0;
        wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;

        // Reads and busy while reset is held
        repeat (3) cyc();
        push("rst_busy_a", 32'd1);   pop_chk(32'(busy_a));
        push("rst_rd_a0", A_INIT);   pop_chk(rd_data_a[31:0]);
        push("rst_rd_a1", A_INIT);   pop_chk(rd_data_a[63:32]);
        push("rst_rd_c2", C_INIT);   pop_chk(rd_data_c[95:64]);

        rst_n = 1'b1;
        push("rel_busy_a", 32'd1);   #1; pop_chk(32'(busy_a));
        wait_clear("por", 16, 16, 12);
        read_all_a("por", A_INIT);

        // Byte strobes on the no-bypass instance
        cyc();
        wr_en_b = 1'b1; wr_addr = 4'd5; wr_data = 32'h1122_3344; wr_strb = 4'b0101;
        rd_addr_b = {4'd4, 4'd5};
        push("b_nobyp_old", 32'h0);  #1; pop_chk(rd_data_b[31:0]);
        cyc();
        wr_data = 32'hAABB_CCDD; wr_strb = 4'b1010;
        push("b_strb_0101", 32'h0022_0044); #1; pop_chk(rd_data_b[31:0]);
        cyc();
        wr_en_b = 1'b0;
        push("b_strb_1010", 32'hAA22_CC44); #1; pop_chk(rd_data_b[31:0]);

        // Bypass disabled: old contents until the edge
        cyc();
        wr_en_b = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFF_FFFF; wr_strb = 4'b0011;
        rd_addr_b = {4'd4, 4'd3};
        push("b_nobyp_p0", 32'h0); push("b_nobyp_p1", 32'h0);
        #1; pop_chk(rd_data_b[31:0]); pop_chk(rd_data_b[63:32]);
        cyc();
        wr_en_b = 1'b0;
        push("b_after_p0", 32'h0000_FFFF); push("b_after_p1", 32'h0);
        #1; pop_chk(rd_data_b[31:0]); pop_chk(rd_data_b[63:32]);

        // Bypass enabled: merged value visible in the same cycle
        cyc();
        wr_en_a = 1'b1; wr_addr = 4'd3; wr_data = 32'h0; wr_strb = 4'b1111;
        cyc();
        wr_data = 32'hFFFF_FFFF; wr_strb = 4'b0011; rd_addr_a = {4'd4, 4'd3};
        push("a_byp_p0", 32'h0000_FFFF); push("a_byp_p1", A_INIT);
        #1; pop_chk(rd_data_a[31:0]); pop_chk(rd_data_a[63:32]);
        cyc();
        wr_en_a = 1'b0;
        push("a_byp_stored", 32'h0000_FFFF); #1; pop_chk(rd_data_a[31:0]);

        // Fill, then clear on request
        for (int i = 0; i < 16; i++) begin
            cyc();
            wr_en_a = 1'b1; wr_addr = 4'(i); wr_data = 32'h5A5A_5A5A; wr_strb = 4'b1111;
        end
        cyc();
        wr_en_a = 1'b0; rd_addr_a = {4'd15, 4'd0};
        push("fill_a0", 32'h5A5A_5A5A); push("fill_a15", 32'h5A5A_5A5A);
        #1; pop_chk(rd_data_a[31:0]); pop_chk(rd_data_a[63:32]);

        cyc();
        clear_req_a = 1'b1; wr_en_a = 1'b1; wr_addr = 4'd2; wr_data = 32'h1234_5678;
        cyc();
        clear_req_a = 1'b0; wr_en_a = 1'b0;
        push("clr_busy_rise", 32'd1); push("clr_rd_masked", A_INIT);
        #1; pop_chk(32'(busy_a)); pop_chk(rd_data_a[31:0]);
        repeat (5) cyc();
        // Mid-sweep write to an already-cleared entry and a repeated request
        wr_en_a = 1'b1; wr_addr = 4'd0; wr_data = 32'h0BAD_BAD0; wr_strb = 4'b1111;
        clear_req_a = 1'b1; rd_addr_a = {4'd12, 4'd0};
        push("clr_mid_p1", A_INIT); #1; pop_chk(rd_data_a[63:32]);
        cyc();
        wr_en_a = 1'b0; clear_req_a = 1'b0;
        wait_clear("clr_req", 10, 0, 0);
        read_all_a("clr", A_INIT);

        // Async reset in the middle of a sweep
        cyc();
        clear_req_a = 1'b1;
        cyc();
        clear_req_a = 1'b0;
        repeat (7) cyc();
        rst_n = 1'b0;
        push("midrst_busy", 32'd1); #1; pop_chk(32'(busy_a));
        cyc();
        cyc();
        rst_n = 1'b1;
        push("midrst_rel_busy", 32'd1); #1; pop_chk(32'(busy_a));
        wait_clear("midrst", 16, 16, 12);

        // Depth-12, three ports: out-of-range write and read
        cyc();
        wr_en_c = 1'b1; wr_addr = 4'd13; wr_data = 32'h1234_5678; wr_strb = 4'b1111;
        rd_addr_c = {4'd14, 4'd1, 4'd13};
        push("c_oor_p0", C_INIT); push("c_oor_p1", C_INIT); push("c_oor_p2", C_INIT);
        #1; pop_chk(rd_data_c[31:0]); pop_chk(rd_data_c[63:32]); pop_chk(rd_data_c[95:64]);
        cyc();
        wr_en_c = 1'b0;
        read_all_c("c_drop", C_INIT);

        // Last entry, bypass merge onto INIT, all ports on one address
        cyc();
        wr_en_c = 1'b1; wr_addr = 4'd11; wr_data = 32'h0BAD_F00D; wr_strb = 4'b0110;
        rd_addr_c = {4'd11, 4'd11, 4'd11};
        for (int p = 0; p < 3; p++) push($sformatf("c_byp_p%0d", p), 32'hC0AD_F012);
        #1; pop_chk(rd_data_c[31:0]); pop_chk(rd_data_c[63:32]); pop_chk(rd_data_c[95:64]);
        cyc();
        wr_en_c = 1'b0;
        for (int p = 0; p < 3; p++) push($sformatf("c_same_p%0d", p), 32'hC0AD_F012);
        #1; pop_chk(rd_data_c[31:0]); pop_chk(rd_data_c[63:32]); pop_chk(rd_data_c[95:64]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lut_ram_mp.md
Name: lut_ram_mp

Overview:
- Parametrised multi-read-port LUT RAM: next generation of the single-port distributed RAM.
- Adds N asynchronous read ports, byte-strobed writes, optional write-to-read bypass, and a hardware clear sequencer that fills the array with INIT_VALUE after reset or on request.
- Intended as the backing store for register files, CSR shadows and small tables in the core.

Parameters:
- LUT_WIDTH, 32: data width in bits; must be a multiple of 8 when BYTE_WR_EN=1.
- LUT_DEPTH, 256: number of entries, ≥2; need not be a power of 2. AW = $clog2(LUT_DEPTH).
- NUM_RD_PORTS, 2: number of independent asynchronous read ports, ≥1.
- BYTE_WR_EN, 1: 1 = wr_strb honoured; 0 = wr_strb ignored, full-word writes.
- WR_BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports; 0 = read returns the stored value.
- INIT_VALUE, 0: LUT_WIDTH-bit value written to every entry by the clear sequencer.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable, active high.
- wr_addr  in  AW  write address.
- wr_data  in  LUT_WIDTH  write data.
- wr_strb  in  LUT_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_addr  in  NUM_RD_PORTS*AW  packed read addresses; port p uses slice [p*AW +: AW].
- rd_data  out  NUM_RD_PORTS*LUT_WIDTH  packed read data; port p uses slice [p*LUT_WIDTH +: LUT_WIDTH].
- clear_req  in  1  single-cycle pulse requesting a full re-clear.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- State machine: CLEAR, IDLE. The async reset forces state=CLEAR, clr_addr=0, busy=1. The memory array itself is not reset.
- CLEAR:
  - Each cycle writes mem[clr_addr] <= INIT_VALUE as a full word, ignoring strobes.
  - clr_addr increments by 1.
  - When clr_addr == LUT_DEPTH-1, that entry is written and the next state is IDLE.
  - Sequence takes exactly LUT_DEPTH cycles after rst_n deasserts. busy is low from the following cycle.
- IDLE:
  - clear_req=1 sets state to CLEAR, clr_addr to 0 and busy to 1 on the next edge.
  - A user write in the same cycle as clear_req still commits.
- busy is a registered output, equal to (state==CLEAR).
- Writes in CLEAR: wr_en ignored and no user write commits. clear_req in CLEAR is ignored; the sweep does not restart.
- Write (IDLE, wr_en=1): on posedge, for each byte i with (wr_strb[i] | ~BYTE_WR_EN), mem[wr_addr] byte i <= wr_data byte i. Other bytes are unchanged.
- wr_addr ≥ LUT_DEPTH (non-power-of-2 depth): write dropped.
- Reads: combinational, zero latency, ports fully independent. Any number of ports may address the same entry.
- rd_addr ≥ LUT_DEPTH: read returns INIT_VALUE.
- While busy=1, all rd_data ports return INIT_VALUE regardless of array contents. This also holds during reset.
- Bypass (WR_BYPASS=1, IDLE, wr_en=1, rd_addr[p]==wr_addr, address in range): rd_data[p] returns the byte-merged value, meaning strobed bytes from wr_data and other bytes from mem.
- Bypass disabled (WR_BYPASS=0): rd_data[p] returns the old contents until the edge.
- Reset mid-operation:
  - rst_n low during CLEAR restarts the sweep from address 0 after release.
  - rst_n low during IDLE discards any pending write and starts a full clear.
- No X on rd_data after busy falls; every in-range entry holds INIT_VALUE or written data.

Test Plan:
- Reset release, LUT_DEPTH=16, INIT_VALUE=32'hDEAD_BEEF → busy=1 for exactly 16 cycles, then 0; all ports read 32'hDEAD_BEEF at addresses 0..15.
- Byte-strobe write after clear (INIT=0): write addr 5, data 32'h1122_3344, strb 4'b0101 → next cycle rd_addr=5 returns 32'h0022_0044. Then strb 4'b1010, data 32'hAABB_CCDD → 32'hAA22_CC44.
- Bypass, WR_BYPASS=1: mem[3]=32'h0, wr_en=1, addr 3, data 32'hFFFF_FFFF, strb 4'b0011, port0 rd_addr=3, port1 rd_addr=4 → same cycle port0=32'h0000_FFFF and port1 unchanged. Repeat with WR_BYPASS=0 → port0=32'h0 until the edge.
- clear_req in IDLE after filling addresses 0..15 with 32'h5A5A_5A5A:
  - busy rises the next cycle.
  - Reads return INIT_VALUE while busy.
  - A write issued mid-clear is ignored.
  - After 16 cycles every entry equals INIT_VALUE.
- Async reset mid-clear: assert rst_n=0 at clr_addr=7, release → busy stays 1 for a full 16 cycles from release; no glitch low on busy.
- LUT_DEPTH=12, NUM_RD_PORTS=3:
  - Clear takes 12 cycles.
  - A write to addr 13 is dropped.
  - rd_addr=14 returns INIT_VALUE.
  - Three ports on the same address return identical data.
